// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and arrow-key decoder.
// The raw PS/2 lines are synchronized and the clock is filtered. 11-bit
// frames are deframed on filtered falling edges. E0/F0 prefixes are tracked
// so that one bit per arrow key stays high while that key is held down.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 130000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILTER_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [FW-1:0] fcnt;
  logic          fclk;
  logic          fclk_d;
  logic          fall;
  logic          data_bit;

  logic [1:0]    state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] tcnt;
  logic          timeout;

  logic          ext;
  logic          brk;

  // Odd parity check: the XOR over the data bits and the parity bit must be 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

  // Two-flop synchronizers for the asynchronous PS/2 lines.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered clock changes only after FILTER_LEN samples in a row that differ from it.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      fclk <= 1'b1;
      fcnt <= '0;
    end else if (clk_sync[1] == fclk) begin
      fcnt <= '0;
    end else if (fcnt == FILTER_LAST) begin
      fclk <= clk_sync[1];
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // Delayed copy of the filtered clock, used for falling-edge detection.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      fclk_d <= 1'b1;
    end else begin
      fclk_d <= fclk;
    end
  end

  // Edge and timeout qualifiers derived from the current state.
  always_comb begin
    fall     = fclk_d & ~fclk;
    data_bit = data_sync[1];
    timeout  = (state != IDLE) && !fall && (tcnt == TIMEOUT_VAL);
  end

  // Frame FSM: start, 8 data bits LSB first, parity, stop, with inactivity timeout.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bitcnt     <= 3'd0;
      shreg      <= 8'h00;
      par_ok     <= 1'b0;
      tcnt       <= '0;
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || fall) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
      if (timeout) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (fall && !data_bit) begin
              state  <= DATA;
              bitcnt <= 3'd0;
            end
          end
          DATA: begin
            if (fall) begin
              shreg  <= {data_bit, shreg[7:1]};
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                state <= PARITY;
              end
            end
          end
          PARITY: begin
            if (fall) begin
              par_ok <= odd_parity_ok(shreg, data_bit);
              state  <= STOP;
            end
          end
          STOP: begin
            if (fall) begin
              state <= IDLE;
              if (par_ok && data_bit) begin
                scan_code  <= shreg;
                scan_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Byte decoder: prefix flags plus the held-arrow bitmask.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      key <= 4'b0000;
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (scan_valid) begin
      if (scan_code == CODE_EXT) begin
        ext <= 1'b1;
      end else if (scan_code == CODE_BRK) begin
        brk <= 1'b1;
      end else begin
        if (ext) begin
          case (scan_code)
            CODE_UP:    key[0] <= ~brk;
            CODE_DOWN:  key[1] <= ~brk;
            CODE_LEFT:  key[2] <= ~brk;
            CODE_RIGHT: key[3] <= ~brk;
            default:    key    <= key;
          endcase
        end
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

PS/2 keyboard receiver and arrow-key decoder that produces the held-key bitmask consumed by the car controller's `key[3:0]` input. It oversamples the keyboard's `ps2_clk`/`ps2_data` lines in the `pclk` domain and deframes 11-bit PS/2 frames. It tracks the E0 (extended) and F0 (break) prefixes and holds one bit per arrow key while that key is down. It sits between the board's PS/2 pins and the car controller, in the same `pclk` domain (65 MHz, 1024x768 timing).

## Interface
- `FILTER_LEN`, 8: consecutive equal `pclk` samples needed before the filtered `ps2_clk` level changes.
- `TIMEOUT_CYCLES`, 130000: `pclk` cycles without a falling edge before a partially received frame is abandoned (2 ms at 65 MHz).
- `pclk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `pclk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `pclk`.
- `key`  out  4  held arrow keys: [0] up, [1] down, [2] left, [3] right (matches car controller KEY_UP/DOWN/LEFT/RIGHT).
- `scan_code`  out  8  last correctly received byte.
- `scan_valid`  out  1  one-cycle pulse when `scan_code` updates.
- `frame_err`  out  1  one-cycle pulse on parity, stop or timeout error.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - Filtered clock `fclk` resets to 1. It takes the synchronized level only after `FILTER_LEN` consecutive identical samples.
  - `fall` is high for exactly one cycle when `fclk` goes 1->0. Data is sampled only in that cycle.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP; a 3-bit bit counter; an 8-bit shift register filled LSB first):
  - IDLE: on `fall` with data 0 (start bit), go to DATA with count 0. On `fall` with data 1, stay in IDLE; this is not an error.
  - DATA: on each `fall`, shift in data. After the 8th bit, go to PARITY.
  - PARITY: sample the parity bit and compute odd parity over the 8 data bits plus the parity bit. Go to STOP.
  - STOP: sample the stop bit and return to IDLE. If parity is OK and stop = 1, the byte is accepted. Otherwise `frame_err` pulses and the byte is discarded.
  - Timeout: a cycle counter clears on every `fall` and counts only while the FSM is not in IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE and `frame_err` pulses.
- **Byte decoder** (flags `ext`, `brk`):
  - 0xE0 sets `ext`. 0xF0 sets `brk`. Neither changes `key`.
  - Any other byte with `ext` = 1 and code 0x75, 0x72, 0x6B or 0x74 updates the up, down, left or right bit respectively. The bit is set if `brk` = 0 and cleared if `brk` = 1.
  - Every other byte changes no key bits.
  - Both flags clear after any non-prefix byte and on any `frame_err`.
- Multiple keys may be held at once. `key` is a bitmask, not a one-hot value; combinations are the consumer's concern.
- `scan_valid` pulses for every accepted byte, including prefixes and ignored codes.

## Timing
- Let E be the cycle with `fall` = 1 for the stop bit.
  - `scan_code`/`scan_valid`, or `frame_err`, are registered at E+1.
  - `key` updates at E+2.
- Input latency from a raw `ps2_clk` edge to `fall` is 2 + `FILTER_LEN` cycles, ±1.
- A timeout `frame_err` is asserted at most 1 cycle after the counter reaches `TIMEOUT_CYCLES`.
- Reset values: `key` = 0, `scan_code` = 0x00, `scan_valid` = 0, `frame_err` = 0, FSM in IDLE, `fclk` = 1, `ext` = `brk` = 0, all counters 0.
- Reset mid-frame discards the partial frame. The first complete frame after release decodes normally.
- `scan_valid` and `frame_err` are never asserted in the same cycle.
- A glitch on `ps2_clk` shorter than `FILTER_LEN` cycles produces no `fall`.

## Test plan
- Send E0 75 -> `key` = 4'b0001 at E+2 of the second frame. Then send E0 F0 75 -> `key` = 4'b0000.
- Send E0 75, then E0 74 -> `key` = 4'b1001. Then E0 F0 75 -> `key` = 4'b1000.
- Send 0x72 with the parity bit inverted -> single `frame_err` pulse, no `scan_valid`, `key` unchanged. A following E0 72 -> `key` = 4'b0010.
- Send non-extended 0x75 -> `scan_valid` pulse with `scan_code` = 0x75, `key` stays 4'b0000. A following E0 6B -> `key` = 4'b0100, proving `ext` did not leak.
- Send a start bit plus 4 data bits, then hold lines high -> `frame_err` after `TIMEOUT_CYCLES`. A following E0 75 decodes to 4'b0001. A 3-cycle low glitch on `ps2_clk` (`FILTER_LEN` = 8) -> no bit shifted in.
- With up held (`key` = 4'b0001), assert `rst` for 2 cycles mid-frame -> `key` = 0 immediately (asynchronous). After release, E0 74 -> `key` = 4'b1000.
